// File: rtl/rmii_rx_deframer.sv
// RMII receive deframer: packs LSB-first dibits into bytes, runs CRC-32 over the
// whole frame, holds back the trailing 4-byte FCS and reports frame status at end.
module rmii_rx_deframer #(
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  in,
    input  logic        inclk,
    input  logic        in_done,
    output logic [7:0]  out,
    output logic        outclk,
    output logic        done,
    output logic        fcs_ok,
    output logic        err,
    output logic [10:0] len
);

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [10:0] MIN_LEN_W   = 11'(MIN_LEN);
    localparam logic [10:0] MAX_LEN_W   = 11'(MAX_LEN);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      phase_q, phase_d;
    logic [7:0]      byte_q, byte_d;
    logic [31:0]     crc_q, crc_d;
    logic [3:0][7:0] hold_q, hold_d;
    logic [2:0]      fill_q, fill_d;
    logic [10:0]     cnt_q, cnt_d;
    logic            ovs_q, ovs_d;
    logic [7:0]      out_q, out_d;
    logic            outclk_q, outclk_d;
    logic            done_q, done_d;
    logic            fcs_ok_q, fcs_ok_d;
    logic            err_q, err_d;
    logic [10:0]     len_q, len_d;

    // Frame context as seen by the current dibit: a fresh frame starts from cleared state.
    logic [1:0]      phase_c;
    logic [31:0]     crc_c;
    logic [2:0]      fill_c;
    logic [10:0]     cnt_c;
    logic            ovs_c;
    logic [7:0]      byte_c;

    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            r = (r >> 1) ^ (((r[0] ^ d[i]) == 1'b1) ? CRC_POLY : 32'h0);
        end
        return r;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch can be inferred.
        state_d  = state_q;
        phase_d  = phase_q;
        byte_d   = byte_q;
        crc_d    = crc_q;
        hold_d   = hold_q;
        fill_d   = fill_q;
        cnt_d    = cnt_q;
        ovs_d    = ovs_q;
        out_d    = out_q;
        outclk_d = 1'b0;
        done_d   = 1'b0;
        fcs_ok_d = fcs_ok_q;
        err_d    = err_q;
        len_d    = len_q;

        phase_c  = (state_q == IDLE) ? 2'd0     : phase_q;
        crc_c    = (state_q == IDLE) ? CRC_INIT : crc_q;
        fill_c   = (state_q == IDLE) ? 3'd0     : fill_q;
        cnt_c    = (state_q == IDLE) ? 11'd0    : cnt_q;
        ovs_c    = (state_q == IDLE) ? 1'b0     : ovs_q;
        byte_c   = byte_q;
        byte_c[{phase_c, 1'b0} +: 2] = in;

        if (in_done) begin
            // in_done wins over a simultaneous inclk; that dibit is dropped.
            state_d = IDLE;
            done_d  = 1'b1;
            if (state_q == RECV) begin
                fcs_ok_d = (crc_q == CRC_RESIDUE) && (phase_q == 2'd0) && (fill_q == 3'd4);
                err_d    = (phase_q != 2'd0) || (cnt_q < MIN_LEN_W) || ovs_q;
                len_d    = cnt_q;
            end else begin
                fcs_ok_d = 1'b0;
                err_d    = 1'b1;
                len_d    = 11'd0;
            end
        end else if (inclk) begin
            state_d = RECV;
            byte_d  = byte_c;
            phase_d = phase_c + 2'd1;
            crc_d   = crc_dibit(crc_c, in);
            fill_d  = fill_c;
            cnt_d   = cnt_c;
            ovs_d   = ovs_c;
            if (phase_c == 2'd3) begin
                hold_d = {byte_c, hold_q[3:1]};
                if (fill_c == 3'd4) begin
                    if (cnt_c < MAX_LEN_W) begin
                        out_d    = hold_q[0];
                        outclk_d = 1'b1;
                        cnt_d    = cnt_c + 11'd1;
                    end else begin
                        ovs_d = 1'b1;
                    end
                end else begin
                    fill_d = fill_c + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            phase_q  <= 2'd0;
            crc_q    <= CRC_INIT;
            fill_q   <= 3'd0;
            cnt_q    <= 11'd0;
            ovs_q    <= 1'b0;
            out_q    <= 8'd0;
            outclk_q <= 1'b0;
            done_q   <= 1'b0;
            fcs_ok_q <= 1'b0;
            err_q    <= 1'b0;
            len_q    <= 11'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q  <= state_d;
            phase_q  <= phase_d;
            crc_q    <= crc_d;
            fill_q   <= fill_d;
            cnt_q    <= cnt_d;
            ovs_q    <= ovs_d;
            out_q    <= out_d;
            outclk_q <= outclk_d;
            done_q   <= done_d;
            fcs_ok_q <= fcs_ok_d;
            err_q    <= err_d;
            len_q    <= len_d;
        end
    end

    // NOTE: byte and holdback storage is not reset; fill_q gates every read of it.
    always_ff @(posedge clk) begin
        byte_q <= byte_d;
        hold_q <= hold_d;
    end

    assign out    = out_q;
    assign outclk = outclk_q;
    assign done   = done_q;
    assign fcs_ok = fcs_ok_q;
    assign err    = err_q;
    assign len    = len_q;

endmodule

// File: tb/tb_rmii_rx_deframer.sv
// Scoreboard bench for rmii_rx_deframer: three instances (default, runt limit, oversize
// limit) share one dibit stream; a monitor checks each instance against its own queues.
module tb_rmii_rx_deframer;

    typedef struct packed {
        logic        fcs_ok;
        logic        err;
        logic [10:0] len;
    } done_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  in_d;
    logic        inclk;
    logic        in_done;

    logic [7:0]  out_w    [3];
    logic        outclk_w [3];
    logic        done_w   [3];
    logic        fcs_ok_w [3];
    logic        err_w    [3];
    logic [10:0] len_w    [3];

    int          checks   = 0;
    int          failures = 0;

    logic [7:0]  exp_bytes [3][$];
    done_t       exp_done  [3][$];
    logic [7:0]  good      [13];
    logic [7:0]  eb;
    done_t       ed;

    always #10 clk = ~clk;

    rmii_rx_deframer #(.MIN_LEN(1), .MAX_LEN(1518)) dut_a (
        .clk(clk), .reset(reset), .in(in_d), .inclk(inclk), .in_done(in_done),
        .out(out_w[0]), .outclk(outclk_w[0]), .done(done_w[0]),
        .fcs_ok(fcs_ok_w[0]), .err(err_w[0]), .len(len_w[0])
    );

    rmii_rx_deframer #(.MIN_LEN(60), .MAX_LEN(1518)) dut_r (
        .clk(clk), .reset(reset), .in(in_d), .inclk(inclk), .in_done(in_done),
        .out(out_w[1]), .outclk(outclk_w[1]), .done(done_w[1]),
        .fcs_ok(fcs_ok_w[1]), .err(err_w[1]), .len(len_w[1])
    );

    rmii_rx_deframer #(.MIN_LEN(1), .MAX_LEN(4)) dut_o (
        .clk(clk), .reset(reset), .in(in_d), .inclk(inclk), .in_done(in_done),
        .out(out_w[2]), .outclk(outclk_w[2]), .done(done_w[2]),
        .fcs_ok(fcs_ok_w[2]), .err(err_w[2]), .len(len_w[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever an instance presents a byte or end of frame.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (outclk_w[i] === 1'b1) begin
                if (exp_bytes[i].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_outclk inst%0d: got byte %h, required no byte", i, out_w[i]);
                end else begin
                    eb = exp_bytes[i].pop_front();
                    check($sformatf("out_byte inst%0d", i), {24'd0, out_w[i]}, {24'd0, eb});
                end
            end
            if (done_w[i] === 1'b1) begin
                check($sformatf("done_outclk_overlap inst%0d", i), {31'd0, outclk_w[i]}, 32'd0);
                if (exp_done[i].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done inst%0d: got done, required none", i);
                end else begin
                    ed = exp_done[i].pop_front();
                    check($sformatf("fcs_ok inst%0d", i), {31'd0, fcs_ok_w[i]}, {31'd0, ed.fcs_ok});
                    check($sformatf("err inst%0d", i), {31'd0, err_w[i]}, {31'd0, ed.err});
                    check($sformatf("len inst%0d", i), {21'd0, len_w[i]}, {21'd0, ed.len});
                end
            end
        end
    end

    task automatic drive(input logic c, input logic d, input logic [1:0] dib);
        @(posedge clk);
        #1;
        inclk   = c;
        in_done = d;
        in_d    = dib;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 2'b00);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic gap);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, b[2*k +: 2]);
            if (gap) idle(1);
        end
    endtask

    task automatic send_frame(input logic [7:0] last, input logic gap);
        for (int k = 0; k < 12; k++) send_byte(good[k], gap);
        send_byte(last, gap);
    endtask

    task automatic pulse_done();
        drive(1'b0, 1'b1, 2'b00);
    endtask

    task automatic push_bytes(input int i, input int n);
        for (int k = 0; k < n; k++) exp_bytes[i].push_back(good[k]);
    endtask

    task automatic push_done(input int i, input logic f, input logic e, input logic [10:0] l);
        done_t d;
        d.fcs_ok = f;
        d.err    = e;
        d.len    = l;
        exp_done[i].push_back(d);
    endtask

    task automatic expect_good();
        push_bytes(0, 9); push_done(0, 1'b1, 1'b0, 11'd9);
        push_bytes(1, 9); push_done(1, 1'b1, 1'b1, 11'd9);
        push_bytes(2, 4); push_done(2, 1'b1, 1'b1, 11'd4);
    endtask

    task automatic expect_bad_fcs();
        push_bytes(0, 9); push_done(0, 1'b0, 1'b0, 11'd9);
        push_bytes(1, 9); push_done(1, 1'b0, 1'b1, 11'd9);
        push_bytes(2, 4); push_done(2, 1'b0, 1'b1, 11'd4);
    endtask

    task automatic expect_misaligned();
        push_bytes(0, 9); push_done(0, 1'b0, 1'b1, 11'd9);
        push_bytes(1, 9); push_done(1, 1'b0, 1'b1, 11'd9);
        push_bytes(2, 4); push_done(2, 1'b0, 1'b1, 11'd4);
    endtask

    task automatic check_cleared(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_out inst%0d", tag, i),    {24'd0, out_w[i]},    32'd0);
            check($sformatf("%s_outclk inst%0d", tag, i), {31'd0, outclk_w[i]}, 32'd0);
            check($sformatf("%s_done inst%0d", tag, i),   {31'd0, done_w[i]},   32'd0);
            check($sformatf("%s_fcs_ok inst%0d", tag, i), {31'd0, fcs_ok_w[i]}, 32'd0);
            check($sformatf("%s_err inst%0d", tag, i),    {31'd0, err_w[i]},    32'd0);
            check($sformatf("%s_len inst%0d", tag, i),    {21'd0, len_w[i]},    32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        good = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                 8'h26, 8'h39, 8'hF4, 8'hCB};
        reset   = 1'b1;
        inclk   = 1'b0;
        in_done = 1'b0;
        in_d    = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_cleared("reset");
        @(posedge clk);
        #1 reset = 1'b0;
        idle(2);

        expect_good();
        send_frame(8'hCB, 1'b0);
        pulse_done();
        idle(3);

        expect_bad_fcs();
        send_frame(8'hCA, 1'b0);
        pulse_done();
        idle(3);

        expect_misaligned();
        send_frame(8'hCB, 1'b0);
        drive(1'b1, 1'b0, 2'b01);
        pulse_done();
        idle(3);

        // inclk gaps after every dibit must not disturb the frame
        expect_good();
        send_frame(8'hCB, 1'b1);
        pulse_done();
        idle(3);

        // Abort after 6 bytes: only the first two bytes have left the holdback.
        for (int i = 0; i < 3; i++) push_bytes(i, 2);
        for (int k = 0; k < 6; k++) send_byte(good[k], 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        inclk = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_cleared("midreset");
        idle(1);

        expect_good();
        send_frame(8'hCB, 1'b0);
        pulse_done();

        // back-to-back: second frame starts the cycle after in_done
        expect_bad_fcs();
        send_frame(8'hCA, 1'b0);
        pulse_done();
        idle(3);

        for (int i = 0; i < 3; i++) push_done(i, 1'b0, 1'b1, 11'd0);
        pulse_done();
        idle(20);

        for (int i = 0; i < 3; i++) begin
            check($sformatf("bytes_left inst%0d", i), exp_bytes[i].size(), 32'd0);
            check($sformatf("dones_left inst%0d", i), exp_done[i].size(), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rmii_rx_deframer.md
# rmii_rx_deframer

Sits directly downstream of the RMII receive driver and consumes its dibit stream: `in`, `inclk` and `in_done`. It packs dibits into bytes LSB-first and runs the Ethernet CRC-32 over every received byte. A 4-byte holdback strips the trailing FCS before bytes are forwarded. At frame end it reports FCS validity, payload length and framing errors to the MAC-layer consumer.

## Interface
- `MIN_LEN`, default 60: minimum forwarded byte count (FCS excluded); shorter frames are flagged as errors.
- `MAX_LEN`, default 1518: maximum forwarded byte count; bytes beyond this are dropped and the frame is flagged.
- `clk`, input, 1: 50 MHz REF_CLK domain, same clock as the RMII driver.
- `reset`, input, 1: synchronous, active-high.
- `in`, input, 2: received dibit; bit 0 is the earlier bit on the wire.
- `inclk`, input, 1: level qualifier; every cycle it is high, `in` holds one new dibit.
- `in_done`, input, 1: one-cycle pulse marking end of frame; never high in the same cycle as `inclk`.
- `out`, output, 8: forwarded byte.
- `outclk`, output, 1: one-cycle pulse per valid `out` byte.
- `done`, output, 1: one-cycle end-of-frame pulse; `fcs_ok`, `err` and `len` are valid in this cycle.
- `fcs_ok`, output, 1: CRC residue matched; held until the next `done`.
- `err`, output, 1: misaligned, runt or oversize frame; held until the next `done`.
- `len`, output, 11: number of bytes forwarded; held until the next `done`.

## Operation
- States: `IDLE` and `RECV`.
- In `IDLE`, the first cycle with `inclk` high moves to `RECV`.
  - Entering `RECV` clears the dibit counter, the CRC register (initialised to 0xFFFFFFFF), the holdback fill count and the byte counter.
  - The dibit on that entry cycle is processed normally.
- Dibit packing:
  - A 2-bit phase counter places the dibit into `byte[2*phase +: 2]`.
  - When phase 3 completes, the byte is pushed into the holdback.
- CRC:
  - Reflected polynomial 0xEDB88320, updated 2 bits per dibit.
  - FCS bytes are included in the update.
  - A valid frame leaves the register (un-inverted) equal to 0xDEBB20E3.
- Holdback:
  - A 4-entry byte shift register.
  - A push while it holds 4 bytes emits the oldest byte on `out` with an `outclk` pulse.
  - That emission increments `len`, which saturates at `MAX_LEN`.
- Oversize: once `len == MAX_LEN`, further emissions are suppressed (no `outclk`) and `err` is set at `done`.
- `in_done` while in `RECV`:
  - Return to `IDLE` and pulse `done` next cycle.
  - `fcs_ok` = (CRC register == 0xDEBB20E3) AND phase == 0 AND holdback full.
  - `err` = phase != 0 (misaligned) OR `len < MIN_LEN` OR oversize.
  - Bytes left in the holdback are discarded; they are the FCS.
- `in_done` while in `IDLE`: produces `done` with `fcs_ok=0`, `err=1`, `len=0`.
- `inclk` dropping without `in_done` holds state; the frame continues when `inclk` returns.
- Reset values:
  - `out=0`, `outclk=0`, `done=0`, `fcs_ok=0`, `err=0`, `len=0`.
  - State `IDLE`; CRC register 0xFFFFFFFF.
  - Reset mid-frame abandons the frame silently: no `done` pulse.

## Timing
- `outclk` and `out` are registered: they appear one cycle after the `inclk` cycle carrying dibit 3 of the 5th, 6th, … byte.
- `done` is registered: it appears one cycle after `in_done`.
- The final `outclk` never coincides with `done`.
- Throughput: at most one `outclk` every 4 cycles.
- `in_done` and `inclk` high in the same cycle is illegal; the design gives `in_done` priority and ignores that dibit.
- Back-to-back frames: `inclk` may return in the cycle after `in_done`.
  - The new frame starts cleanly.
  - `done` for the previous frame still pulses with the previous frame's results.

## Test plan
- Good frame (`MIN_LEN=1`): feed bytes 0x31..0x39 ("123456789") followed by FCS 0x26 0x39 0xF4 0xCB as dibits, then `in_done`.
  - Required: 9 `outclk` pulses carrying 0x31..0x39 in order.
  - Then `done` with `fcs_ok=1`, `err=0`, `len=9`.
- Corrupted FCS: same frame with the last byte 0xCA → `done` with `fcs_ok=0`, `err=0`, `len=9`.
- Misaligned: same good frame plus one extra dibit 2'b01 before `in_done` → `fcs_ok=0`, `err=1`.
- Runt (`MIN_LEN=60`): the good 13-byte frame → `fcs_ok=1`, `err=1`, `len=9`.
- Oversize (`MAX_LEN=4`): the good frame → 4 `outclk` pulses (0x31..0x34), then `done` with `err=1`, `len=4`.
- Reset mid-frame: assert `reset` after 6 bytes, then send the good frame.
  - Required: no `done` for the aborted frame.
  - The second frame yields 9 bytes and `fcs_ok=1`.
  - Repeat with a back-to-back frame to check the second frame's `done` results.
